// File: rtl/main_memory_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port; one access in flight.
// Latency: request sampled at edge N -> valid pulse in the cycle after edge N+ACCESS_CYCLES; requests ignored outside IDLE.
// Backpressure: requesters hold req until their valid pulse; MEM_ARB_RR_EN selects round-robin tie-breaking (default: data wins).
module main_memory_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic [31:0]       ifData,
    output logic              ifValid,
    input  logic              dReq,
    input  logic              dWrite,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [31:0]       dWdata,
    output logic [31:0]       dRdata,
    output logic              dValid,
    output logic [ADDR_W-1:0] memAddress,
    output logic              memReadEnable,
    output logic              memWriteEnable,
    output logic [31:0]       memDataIn,
    input  logic [31:0]       memDataOut
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              last_d, last_d_nx;
    logic              grant_d;
    logic              store_busy;
    logic [ADDR_W-1:0] addr_nx;
    logic [31:0]       din_nx, ifdata_nx, drdata_nx;
    logic              re_nx, we_nx, ifv_nx, dv_nx;

`ifdef MEM_ARB_RR_EN
    // Tie goes to the port that did not win last time.
    assign grant_d = dReq && (!ifReq || !last_d);
`else
    assign grant_d = dReq;
`endif

    // A store is the only data access issued with readEnable low.
    assign store_busy = (state == BUSY_D) && !memReadEnable;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:           if (ifReq || dReq) state_nx = grant_d ? BUSY_D : BUSY_I;
            BUSY_I, BUSY_D: if (cnt == '0) state_nx = RESP;
            RESP:           state_nx = IDLE;
            default:        state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx    = cnt;
        last_d_nx = last_d;
        addr_nx   = memAddress;
        din_nx    = memDataIn;
        re_nx     = memReadEnable;
        we_nx     = memWriteEnable;
        ifdata_nx = ifData;
        drdata_nx = dRdata;
        ifv_nx    = 1'b0;
        dv_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (ifReq || dReq) begin
                    last_d_nx = grant_d;
                    addr_nx   = grant_d ? dAddr : ifAddr;
                    din_nx    = dWdata;
                    cnt_nx    = CNT_INIT;
                    re_nx     = !(grant_d && dWrite);
                    we_nx     = grant_d && dWrite && (ACCESS_CYCLES == 1);
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                    // Write strobe lands on the final busy cycle only.
                    we_nx  = store_busy && (cnt == CW'(1));
                end else begin
                    re_nx = 1'b0;
                    we_nx = 1'b0;
                    if (state == BUSY_I) begin
                        ifv_nx    = 1'b1;
                        ifdata_nx = memDataOut;
                    end else begin
                        dv_nx = 1'b1;
                        if (!store_busy) drdata_nx = memDataOut;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            last_d         <= 1'b0;
            memAddress     <= '0;
            memDataIn      <= '0;
            memReadEnable  <= 1'b0;
            memWriteEnable <= 1'b0;
            ifData         <= '0;
            dRdata         <= '0;
            ifValid        <= 1'b0;
            dValid         <= 1'b0;
        end else begin
            cnt            <= cnt_nx;
            last_d         <= last_d_nx;
            memAddress     <= addr_nx;
            memDataIn      <= din_nx;
            memReadEnable  <= re_nx;
            memWriteEnable <= we_nx;
            ifData         <= ifdata_nx;
            dRdata         <= drdata_nx;
            ifValid        <= ifv_nx;
            dValid         <= dv_nx;
        end
    end

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Bench for main_memory_arbiter: timeline model of the main instance plus directed literal checks.
module tb_main_memory_arbiter;

    localparam int AC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ifReq = 0, dReq = 0, dWrite = 0;
    logic [31:0] ifAddr = 0, dAddr = 0, dWdata = 0;
    logic [31:0] ifData, dRdata, memAddress, memDataIn, memDataOut;
    logic        ifValid, dValid, memReadEnable, memWriteEnable;

    logic        d2Req = 0;
    logic [31:0] d2Addr = 0;
    logic [31:0] if2Data, d2Rdata, m2Addr, m2Din, m2Dout;
    logic        if2Valid, d2Valid, m2Re, m2We;

    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];

    main_memory_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifValid(ifValid),
        .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dValid(dValid),
        .memAddress(memAddress), .memReadEnable(memReadEnable),
        .memWriteEnable(memWriteEnable), .memDataIn(memDataIn), .memDataOut(memDataOut)
    );

    main_memory_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifReq(1'b0), .ifAddr(32'd0), .ifData(if2Data), .ifValid(if2Valid),
        .dReq(d2Req), .dWrite(1'b0), .dAddr(d2Addr), .dWdata(32'd0),
        .dRdata(d2Rdata), .dValid(d2Valid),
        .memAddress(m2Addr), .memReadEnable(m2Re),
        .memWriteEnable(m2We), .memDataIn(m2Din), .memDataOut(m2Dout)
    );

    assign memDataOut = {mem[memAddress[11:0]], mem[memAddress[11:0] + 12'd1],
                         mem[memAddress[11:0] + 12'd2], mem[memAddress[11:0] + 12'd3]};
    assign m2Dout     = {mem[m2Addr[11:0]], mem[m2Addr[11:0] + 12'd1],
                         mem[m2Addr[11:0] + 12'd2], mem[m2Addr[11:0] + 12'd3]};

    always @(posedge clk) begin
        if (memWriteEnable) begin
            mem[memAddress[11:0]]         <= memDataIn[31:24];
            mem[memAddress[11:0] + 12'd1] <= memDataIn[23:16];
            mem[memAddress[11:0] + 12'd2] <= memDataIn[15:8];
            mem[memAddress[11:0] + 12'd3] <= memDataIn[7:0];
        end
    end

    int vectors = 0, miscompares = 0;
    int cyc = 0, we_cnt = 0, dv_cnt = 0, we2_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: no valid pulse within bound, expected one (cycle %0d)", nm, cyc);
    endtask

    // Model: each access is a timeline counted from its grant edge.
    // Edges 1..AC after grant: address/readEnable held, write strobe on the last of them.
    // Edge AC: valid pulse with captured data; edge AC+1: idle; next sample at AC+2.
    logic        chk_en = 0;
    int          m_ph = 0, m_k = 0;
    logic        m_d = 0, m_wr = 0, m_last = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [31:0] exp_ifd = 0, exp_drd = 0, exp_addr = 0, exp_din = 0;
    logic        exp_ifv = 0, exp_dv = 0, exp_re = 0, exp_we = 0;

    function automatic logic pick_data(input logic ir, input logic dr, input logic last);
`ifdef MEM_ARB_RR_EN
        return dr && (!ir || !last);
`else
        return dr;
`endif
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a[11:0]], ref_mem[a[11:0] + 12'd1],
                ref_mem[a[11:0] + 12'd2], ref_mem[a[11:0] + 12'd3]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            chk_en <= 1; m_ph <= 0; m_last <= 0;
            exp_ifd <= 0; exp_drd <= 0; exp_addr <= 0; exp_din <= 0;
            exp_ifv <= 0; exp_dv <= 0; exp_re <= 0; exp_we <= 0;
        end else if (m_ph == 0) begin
            exp_ifv <= 0; exp_dv <= 0;
            if (ifReq || dReq) begin
                m_d      <= pick_data(ifReq, dReq, m_last);
                m_last   <= pick_data(ifReq, dReq, m_last);
                m_wr     <= pick_data(ifReq, dReq, m_last) && dWrite;
                m_addr   <= pick_data(ifReq, dReq, m_last) ? dAddr : ifAddr;
                m_wdata  <= dWdata;
                exp_addr <= pick_data(ifReq, dReq, m_last) ? dAddr : ifAddr;
                exp_din  <= dWdata;
                exp_re   <= !(pick_data(ifReq, dReq, m_last) && dWrite);
                exp_we   <= pick_data(ifReq, dReq, m_last) && dWrite && (AC == 1);
                m_k <= 1; m_ph <= 1;
            end
        end else if (m_ph == 1) begin
            if (m_k < AC) begin
                exp_we <= m_wr && (m_k == AC - 1);
                m_k <= m_k + 1;
            end else begin
                exp_re <= 0; exp_we <= 0; m_ph <= 2;
                if (!m_d) begin
                    exp_ifv <= 1; exp_ifd <= ref_word(m_addr);
                end else begin
                    exp_dv <= 1;
                    if (!m_wr) exp_drd <= ref_word(m_addr);
                    else begin
                        ref_mem[m_addr[11:0]]         <= m_wdata[31:24];
                        ref_mem[m_addr[11:0] + 12'd1] <= m_wdata[23:16];
                        ref_mem[m_addr[11:0] + 12'd2] <= m_wdata[15:8];
                        ref_mem[m_addr[11:0] + 12'd3] <= m_wdata[7:0];
                    end
                end
            end
        end else begin
            exp_ifv <= 0; exp_dv <= 0; m_ph <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ifData", ifData, exp_ifd);
            check("ifValid", ifValid, exp_ifv);
            check("dRdata", dRdata, exp_drd);
            check("dValid", dValid, exp_dv);
            check("memAddress", memAddress, exp_addr);
            check("memDataIn", memDataIn, exp_din);
            check("memReadEnable", memReadEnable, exp_re);
            check("memWriteEnable", memWriteEnable, exp_we);
            check("re_we_exclusive", memReadEnable & memWriteEnable, 0);
            if (memWriteEnable) we_cnt++;
            if (dValid) dv_cnt++;
            if (m2We) we2_cnt++;
        end
    end

    // kind: 1 = data valid, 0 = fetch valid, -1 = timeout
    task automatic wait_any(output int kind, output int at);
        kind = -1; at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dValid) begin kind = 1; at = cyc; break; end
            if (ifValid) begin kind = 0; at = cyc; break; end
        end
        if (kind < 0) timeout("wait_valid");
    endtask

    task automatic d_access(input logic wr, input logic [31:0] a, input logic [31:0] w, output int lat);
        int rq, kind, at;
        @(negedge clk);
        dReq = 1; dWrite = wr; dAddr = a; dWdata = w; rq = cyc;
        wait_any(kind, at);
        dReq = 0;
        check("d_port_served", kind, 1);
        lat = at - rq;
    endtask

    initial begin
        int lat, rq, at, kind, nd, ni, we0, dv0, diff;
        int kinds[4];
        int ats[4];
        int exp_kinds[4];
        for (int i = 0; i < 4096; i++) begin
            mem[i] = i[7:0];
            ref_mem[i] = i[7:0];
        end
        mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
        ref_mem[256] = 8'h11; ref_mem[257] = 8'h22; ref_mem[258] = 8'h33; ref_mem[259] = 8'h44;

        // reset held with a pending load, then released
        dReq = 1; dWrite = 0; dAddr = 32'h100;
        repeat (2) @(negedge clk);
        check("rst_memWriteEnable", memWriteEnable, 0);
        check("rst_memAddress", memAddress, 0);
        check("rst_dValid", dValid, 0);
        rst_n = 1; rq = cyc;
        wait_any(kind, at);
        dReq = 0;
        check("post_reset_grant_kind", kind, 1);
        check("post_reset_latency", at - rq, 3);
        check("post_reset_dRdata", dRdata, 32'h11223344);

        // fetch of 0x100
        @(negedge clk);
        ifReq = 1; ifAddr = 32'h100; rq = cyc;
        wait_any(kind, at);
        ifReq = 0;
        check("fetch_kind", kind, 0);
        check("fetch_latency", at - rq, 3);
        check("fetch_ifData", ifData, 32'h11223344);

        // store then load back
        #1 we0 = we_cnt;
        d_access(1, 32'h200, 32'hDEADBEEF, lat);
        #1;
        check("store_latency", lat, 3);
        check("store_we_pulses", we_cnt - we0, 1);
        check("store_mem_bytes", {mem[512], mem[513], mem[514], mem[515]}, 32'hDEADBEEF);
        d_access(0, 32'h200, 32'h0, lat);
        check("load_back_dRdata", dRdata, 32'hDEADBEEF);
        check("load_keeps_ifData", ifData, 32'h11223344);

        // both ports held; each port drops after two services
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        ifReq = 1; ifAddr = 32'h104; dReq = 1; dWrite = 0; dAddr = 32'h200;
        nd = 0; ni = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any(kind, at);
            kinds[k] = kind; ats[k] = at;
            if (kind == 1) begin nd++; if (nd == 2) dReq = 0; end
            if (kind == 0) begin ni++; if (ni == 2) ifReq = 0; end
        end
        ifReq = 0; dReq = 0;
`ifdef MEM_ARB_RR_EN
        exp_kinds = '{1, 0, 1, 0};
`else
        exp_kinds = '{1, 1, 0, 0};
`endif
        for (int k = 0; k < 4; k++) check("tie_grant_order", kinds[k], exp_kinds[k]);
        for (int k = 1; k < 4; k++) check("tie_spacing", ats[k] - ats[k-1], 4);

        // store aborted by reset in its first busy cycle
        #1 we0 = we_cnt; dv0 = dv_cnt;
        @(negedge clk);
        dReq = 1; dWrite = 1; dAddr = 32'h300; dWdata = 32'hCAFEF00D;
        @(negedge clk);
        rst_n = 0; dReq = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        #1;
        check("abort_no_we", we_cnt - we0, 0);
        check("abort_no_dValid", dv_cnt - dv0, 0);
        check("abort_mem_unchanged", {mem[768], mem[769], mem[770], mem[771]}, 32'h00010203);

        // single-cycle instance: latency and back-to-back spacing
        @(negedge clk);
        d2Req = 1; d2Addr = 32'h100; rq = cyc; at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d2Valid) begin at = cyc; break; end
        end
        if (at < 0) timeout("ac1_first");
        check("ac1_latency", at - rq, 2);
        check("ac1_dRdata0", d2Rdata, 32'h11223344);
        d2Addr = 32'h104; rq = at; at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d2Valid) begin at = cyc; break; end
        end
        d2Req = 0;
        if (at < 0) timeout("ac1_second");
        check("ac1_spacing", at - rq, 3);
        check("ac1_dRdata1", d2Rdata, 32'h04050607);
        check("ac1_no_write", we2_cnt, 0);

        repeat (3) @(negedge clk);
        diff = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("memory_image", diff, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
